uart_i2c_cmd_bridge: RTL and testbench



---
 rtl/uart_i2c_cmd_bridge_pkg.sv | 31 +++
 rtl/uart_i2c_cmd_bridge_timeout_cnt.sv | 34 +++
 rtl/uart_i2c_cmd_bridge.sv | 163 ++++++++++++++++
 tb/tb_uart_i2c_cmd_bridge.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_i2c_cmd_bridge_pkg.sv
// Shared types and constants for the UART-to-I2C command bridge.
// State encoding, command bytes and response codes.
package uart_i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR_H,
    S_ADDR_L,
    S_DATA,
    S_I2C_REQ,
    S_I2C_WAIT,
    S_RESP,
    S_RESP_WAIT
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  function automatic logic in_frame(state_t s);
    return (s == S_CMD) || (s == S_ADDR_H) ||
           (s == S_ADDR_L) || (s == S_DATA);
  endfunction

  function automatic logic in_i2c(state_t s);
    return (s == S_I2C_REQ) || (s == S_I2C_WAIT);
  endfunction

endpackage

// File: rtl/uart_i2c_cmd_bridge_timeout_cnt.sv
// Saturating 32-bit cycle counter with clear priority.
// hit_o is high while enabled and the count has reached max_i.
module timeout_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] max_i,
  output logic        hit_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = en_i && (cnt_q >= max_i);

endmodule

// File: rtl/uart_i2c_cmd_bridge.sv
// Framed UART command parser driving single-byte EEPROM
// write/read requests on i2c_ctrl and returning one response byte.
module uart_i2c_cmd_bridge
  import uart_i2c_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = 8'h55,
  parameter logic [31:0] RX_GAP_MAX  = 32'd500_000,
  parameter logic [31:0] I2C_TMO_MAX = 32'd5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  input  logic        tx_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_wen,
  output logic        i2c_start,
  output logic        wr_en,
  output logic        rd_en,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  input  logic [7:0]  rd_data,
  input  logic        i2c_end,
  output logic        busy
);

  state_t      state_q;
  logic        op_wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdat_q;
  logic [7:0]  tx_q;
  logic        start_q;
  logic        wen_q;
  logic        ren_q;
  logic        gap_hit;
  logic        tmo_hit;

  timeout_cnt u_gap (
    .clk   (clk),
    .reset (reset),
    .clr_i (rx_rdy || !in_frame(state_q)),
    .en_i  (in_frame(state_q)),
    .max_i (RX_GAP_MAX),
    .hit_o (gap_hit)
  );

  // Cleared outside REQ/WAIT, so the REQ cycle counts as cycle 0.
  timeout_cnt u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr_i (!in_i2c(state_q)),
    .en_i  (in_i2c(state_q)),
    .max_i (I2C_TMO_MAX),
    .hit_o (tmo_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      tx_q    <= '0;
      start_q <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_rdy && (rx_data == HDR_BYTE)) begin
            state_q <= S_CMD;
          end
        end
        S_CMD: begin
          if (rx_rdy) begin
            if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
              op_wr_q <= (rx_data == CMD_WR);
              state_q <= S_ADDR_H;
            end else begin
              tx_q    <= RSP_ERR;
              state_q <= S_RESP;
            end
          end else if (gap_hit) begin
            state_q <= S_IDLE;
          end
        end
        S_ADDR_H: begin
          if (rx_rdy) begin
            addr_q[15:8] <= rx_data;
            state_q      <= S_ADDR_L;
          end else if (gap_hit) begin
            state_q <= S_IDLE;
          end
        end
        S_ADDR_L: begin
          if (rx_rdy) begin
            addr_q[7:0] <= rx_data;
            if (op_wr_q) begin
              state_q <= S_DATA;
            end else begin
              start_q <= 1'b1;
              ren_q   <= 1'b1;
              state_q <= S_I2C_REQ;
            end
          end else if (gap_hit) begin
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (rx_rdy) begin
            wdat_q  <= rx_data;
            start_q <= 1'b1;
            wen_q   <= 1'b1;
            state_q <= S_I2C_REQ;
          end else if (gap_hit) begin
            state_q <= S_IDLE;
          end
        end
        S_I2C_REQ: begin
          state_q <= S_I2C_WAIT;
        end
        S_I2C_WAIT: begin
          if (i2c_end) begin
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            tx_q    <= op_wr_q ? RSP_ACK : rd_data;
            state_q <= S_RESP;
          end else if (tmo_hit) begin
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            tx_q    <= RSP_ERR;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_rdy) begin
            state_q <= S_RESP_WAIT;
          end
        end
        S_RESP_WAIT: begin
          if (!tx_rdy) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Strobe in the first RESP cycle that sees tx_rdy; RESP_WAIT follows.
  assign tx_wen    = !((state_q == S_RESP) && tx_rdy);
  assign tx_data   = tx_q;
  assign i2c_start = start_q;
  assign wr_en     = wen_q;
  assign rd_en     = ren_q;
  assign byte_addr = addr_q;
  assign wr_data   = wdat_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_i2c_cmd_bridge.sv
// Directed bench for uart_i2c_cmd_bridge with a frame-level
// expectation model and a per-cycle scoreboard.
module tb_uart_i2c_cmd_bridge;

  localparam int GAP = 50;
  localparam int TMO = 100;
  localparam int OC_END = 0;
  localparam int OC_TMO = 1;
  localparam int OC_RST = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        tx_rdy;
  logic [7:0]  tx_data;
  logic        tx_wen;
  logic        i2c_start;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] byte_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        i2c_end;
  logic        busy;

  always #5 clk = ~clk;

  uart_i2c_cmd_bridge #(
    .HDR_BYTE    (8'h55),
    .RX_GAP_MAX  (GAP),
    .I2C_TMO_MAX (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .tx_rdy    (tx_rdy),
    .tx_data   (tx_data),
    .tx_wen    (tx_wen),
    .i2c_start (i2c_start),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .byte_addr (byte_addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .i2c_end   (i2c_end),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event seen, none expected", nm);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } req_t;

  req_t       req_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] frm[$];

  // Frame-level model: what request and response a frame must yield.
  function automatic void expect_frm(int oc, logic [7:0] rdd);
    logic [7:0] c;
    req_t       r;
    if (frm.size() < 2 || frm[0] != 8'h55) return;
    c = frm[1];
    if (c != 8'h57 && c != 8'h52) begin
      rsp_q.push_back(8'hEE);
      return;
    end
    r.wr   = (c == 8'h57);
    r.addr = {frm[2], frm[3]};
    r.data = r.wr ? frm[4] : 8'h00;
    req_q.push_back(r);
    if (oc == OC_TMO) rsp_q.push_back(8'hEE);
    else if (oc == OC_END) rsp_q.push_back(r.wr ? 8'hAA : rdd);
  endfunction

  bit prev_low = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_low = 1'b0;
    end else begin
      if (i2c_start) begin
        if (req_q.size() == 0) begin
          fail("unexpected_i2c_start");
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_wr_en", wr_en, r.wr);
          chk("req_rd_en", rd_en, !r.wr);
          chk("req_addr", byte_addr, r.addr);
          if (r.wr) chk("req_wr_data", wr_data, r.data);
        end
      end
      if (!tx_wen) begin
        if (prev_low) fail("double_tx_wen");
        else if (rsp_q.size() == 0) fail("unexpected_tx_wen");
        else begin
          chk("rsp_data", tx_data, rsp_q.pop_front());
          chk("rsp_tx_rdy", tx_rdy, 1'b1);
        end
      end
      prev_low = !tx_wen;
      if (wr_en && rd_en) fail("both_enables");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic end_pulse(int dly, logic [7:0] rdd);
    repeat (dly) tick();
    rd_data = rdd;
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
  endtask

  task automatic finish_resp();
    int n;
    n = 0;
    while (tx_wen && n < 500) begin
      tick();
      n++;
    end
    chk("resp_seen", tx_wen, 1'b0);
    tick();
    tx_rdy = 1'b0;
    tick();
    tick();
    tx_rdy = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("back_to_idle", busy, 1'b0);
  endtask

  initial begin
    int n;
    bit ok;
    reset   = 1'b1;
    rx_data = '0;
    rx_rdy  = 1'b0;
    tx_rdy  = 1'b1;
    rd_data = '0;
    i2c_end = 1'b0;
    tick();
    tick();
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_wen", tx_wen, 1'b1);
    chk("rst_i2c_start", i2c_start, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_addr", byte_addr, 16'h0000);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    frm = {8'h55, 8'h57, 8'h00, 8'h10, 8'h3C};
    expect_frm(OC_END, 8'h00);
    send_frm();
    chk("wr_start_latency", i2c_start, 1'b1);
    tick();
    chk("wr_start_single", i2c_start, 1'b0);
    chk("wr_en_held", wr_en, 1'b1);
    end_pulse(78, 8'h00);
    chk("wr_en_drop", wr_en, 1'b0);
    chk("ack_latency", tx_wen, 1'b0);
    chk("ack_data", tx_data, 8'hAA);
    finish_resp();

    frm = {8'h55, 8'h52, 8'h01, 8'hFF};
    expect_frm(OC_END, 8'h5A);
    send_frm();
    chk("rd_start", i2c_start, 1'b1);
    chk("rd_addr", byte_addr, 16'h01FF);
    chk("rd_no_wr_en", wr_en, 1'b0);
    end_pulse(10, 8'h5A);
    chk("rd_en_drop", rd_en, 1'b0);
    chk("rd_resp", tx_data, 8'h5A);
    finish_resp();

    frm = {8'h55, 8'h41};
    expect_frm(OC_END, 8'h00);
    send_frm();
    chk("bad_no_start", i2c_start, 1'b0);
    finish_resp();
    chk("bad_resp", tx_data, 8'hEE);
    frm = {8'h55, 8'h57, 8'h12, 8'h34, 8'h99};
    expect_frm(OC_END, 8'h00);
    send_frm();
    end_pulse(5, 8'h00);
    finish_resp();

    frm = {8'h55, 8'h52, 8'h00, 8'h01};
    expect_frm(OC_TMO, 8'h00);
    send_frm();
    n = 0;
    while (rd_en && n < 1000) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, TMO + 1);
    chk("tmo_resp", tx_data, 8'hEE);
    finish_resp();

    frm = {8'h55, 8'h52, 8'h00, 8'h02};
    expect_frm(OC_END, 8'hC3);
    send_frm();
    end_pulse(TMO, 8'hC3);
    chk("end_beats_tmo", tx_data, 8'hC3);
    finish_resp();

    end_pulse(2, 8'h77);
    repeat (5) tick();
    chk("stray_end_idle", busy, 1'b0);

    frm = {8'h55, 8'h57, 8'h00};
    send_frm();
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    chk("gap_cycles", n, GAP + 1);
    repeat (5) tick();
    chk("gap_no_resp", tx_wen, 1'b1);
    frm = {8'h55, 8'h57, 8'h00, 8'h20, 8'h11};
    expect_frm(OC_END, 8'h00);
    send_frm();
    end_pulse(3, 8'h00);
    finish_resp();

    tx_rdy = 1'b0;
    frm = {8'h55, 8'h57, 8'h00, 8'h30, 8'h44};
    expect_frm(OC_END, 8'h00);
    send_frm();
    end_pulse(4, 8'h00);
    ok = 1'b1;
    repeat (1000) begin
      if (tx_wen !== 1'b1 || tx_data !== 8'hAA) ok = 1'b0;
      tick();
    end
    chk("hold_stable", ok, 1'b1);
    chk("hold_busy", busy, 1'b1);
    tx_rdy = 1'b1;
    #1;
    chk("hold_release", tx_wen, 1'b0);
    finish_resp();

    frm = {8'h55, 8'h52, 8'h00, 8'h40};
    expect_frm(OC_RST, 8'h00);
    send_frm();
    repeat (5) tick();
    chk("pre_rst_rd_en", rd_en, 1'b1);
    reset = 1'b1;
    tick();
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_rd_en", rd_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    end_pulse(3, 8'h99);
    repeat (20) tick();
    chk("late_end_idle", busy, 1'b0);
    chk("late_end_no_wen", tx_wen, 1'b1);

    chk("req_queue_empty", req_q.size(), 0);
    chk("rsp_queue_empty", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
